pkt_rr_mux: RTL and testbench

PKT_RR_MUX -- requirements
Module: pkt_rr_mux

---
 rtl/pkt_rr_mux_pkg.sv | 15 +
 rtl/pkt_rr_mux_if.sv | 24 ++
 rtl/pkt_rr_arb.sv | 33 +++
 rtl/pkt_rr_mux.sv | 97 +++++++++
 tb/tb_pkt_rr_mux.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_rr_mux_pkg.sv
// Shared types and helpers for the round-robin packet multiplexer.
// The beat width stays a module parameter; only its layout rule lives here.
package pkt_rr_mux_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // The end-of-packet marker is the top bit of every beat.
   function automatic int eop_pos(input int wd);
      return wd - 1;
   endfunction

endpackage

// File: rtl/pkt_rr_mux_if.sv
// Beat-level handshake bundle between the CH input channels, the mux and its sink.
// The slave modport is the mux's view; the master modport is the view of whatever drives it.
interface pkt_rr_mux_if #(
   parameter int WD = 9,
   parameter int CH = 4
);
   logic [CH*WD-1:0]        in_data;
   logic [CH-1:0]           in_valid;
   logic [CH-1:0]           in_ready;
   logic [WD-1:0]           out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [$clog2(CH)-1:0]   out_chan;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_chan
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_chan
   );
endinterface

// File: rtl/pkt_rr_arb.sv
// Round-robin priority select: first requester at or after ptr, wrapping modulo CH.
// Produces a one-hot grant, its index, and whether anything requested at all.
module pkt_rr_arb #(
   parameter int CH = 4
) (
   input  logic [CH-1:0]         req,
   input  logic [$clog2(CH)-1:0] ptr,
   output logic [CH-1:0]         grant,
   output logic [$clog2(CH)-1:0] idx,
   output logic                  any
);
   localparam int CHW = $clog2(CH);

   int c;

   // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      c     = 0;
      for (int i = 0; i < CH; i++) begin
         c = int'(ptr) + i;
         if (c >= CH) c = c - CH;
         if (!any && req[c]) begin
            any      = 1'b1;
            grant[c] = 1'b1;
            idx      = CHW'(c);
         end
      end
   end

endmodule

// File: rtl/pkt_rr_mux.sv
// CH-to-1 packet multiplexer: round-robin arbitration (packet- or beat-granular)
// feeding a single registered output slice, plus a count of delivered packets.
module pkt_rr_mux
   import pkt_rr_mux_pkg::*;
#(
   parameter int WD       = 9,
   parameter int CH       = 4,
   parameter int LOCK_PKT = 1,
   parameter int CW       = 16
) (
   input  logic          clk,
   input  logic          rst,
   pkt_rr_mux_if.slave   bus,
   output logic [CW-1:0] pkt_cnt
);
   localparam int CHW = $clog2(CH);
   localparam int EOP = eop_pos(WD);

   arb_state_e      state_q, state_d;
   logic [CHW-1:0]  ptr_q, ptr_d;
   logic [CHW-1:0]  lock_q, lock_d;
   logic [CHW-1:0]  arb_idx, sel_idx;
   logic [CH-1:0]   arb_grant;
   logic            arb_any, sel_any;
   logic            load_en, accept;
   logic [WD-1:0]   acc_data;

   pkt_rr_arb #(.CH(CH)) u_arb (
      .req   (bus.in_valid),
      .ptr   (ptr_q),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   assign load_en = !bus.out_valid || bus.out_ready;

   // While locked the arbiter result is ignored; the held channel alone may move.
   always_comb begin
      sel_idx      = arb_idx;
      sel_any      = arb_any;
      bus.in_ready = '0;
      acc_data     = '0;
      if (state_q == LOCKED) begin
         sel_idx = lock_q;
         sel_any = bus.in_valid[lock_q];
      end
      if (!rst && load_en)
         bus.in_ready = (state_q == LOCKED) ? (CH'(1) << lock_q) : arb_grant;
      accept = !rst && load_en && sel_any;
      for (int i = 0; i < CH; i++)
         if (sel_idx == CHW'(i)) acc_data = bus.in_data[i*WD +: WD];
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      lock_d  = lock_q;
      if (accept) begin
         if (state_q == IDLE) lock_d = sel_idx;
         if (LOCK_PKT == 0 || acc_data[EOP]) begin
            state_d = IDLE;
            ptr_d   = (sel_idx == CHW'(CH - 1)) ? '0 : sel_idx + CHW'(1);
         end else begin
            state_d = LOCKED;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         lock_q        <= '0;
         bus.out_valid <= 1'b0;
         // NOTE: the data/chan registers are cleared too so the output is fully defined right after reset.
         bus.out_data  <= '0;
         bus.out_chan  <= '0;
         pkt_cnt       <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         lock_q  <= lock_d;
         if (load_en) begin
            bus.out_valid <= accept;
            if (accept) begin
               bus.out_data <= acc_data;
               bus.out_chan <= sel_idx;
            end
         end
         if (bus.out_valid && bus.out_ready && bus.out_data[EOP])
            pkt_cnt <= pkt_cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_pkt_rr_mux.sv
// Directed bench for pkt_rr_mux: per-channel source queues feed the DUT, expected
// beats go into a scoreboard when stimulus is queued and are popped on each output transfer.
module tb_pkt_rr_mux;
   localparam int WD = 9;
   localparam int CH = 4;

   typedef struct packed {
      logic [1:0]    ch;
      logic [WD-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                tb_rst;
   int                  sel;
   logic [CH*WD-1:0]    tb_in_data;
   logic [CH-1:0]       tb_in_valid;
   logic                tb_out_ready;
   logic                rst0, rst1, rst2;

   logic [CH-1:0]       m_in_ready;
   logic                m_out_valid;
   logic [WD-1:0]       m_out_data;
   logic [1:0]          m_out_chan;
   logic [15:0]         m_pkt_cnt;
   logic [15:0]         pc0, pc1;
   logic [3:0]          pc2;

   logic [WD-1:0]       src [CH][$];
   exp_t                sb[$];
   int                  vectors = 0;
   int                  miscompares = 0;
   logic [CH-1:0]       acc;

   pkt_rr_mux_if #(.WD(WD), .CH(CH)) if0 ();
   pkt_rr_mux_if #(.WD(WD), .CH(CH)) if1 ();
   pkt_rr_mux_if #(.WD(WD), .CH(CH)) if2 ();

   assign rst0 = tb_rst || (sel != 0);
   assign rst1 = tb_rst || (sel != 1);
   assign rst2 = tb_rst || (sel != 2);

   assign if0.in_data = tb_in_data;  assign if0.in_valid = tb_in_valid;  assign if0.out_ready = tb_out_ready;
   assign if1.in_data = tb_in_data;  assign if1.in_valid = tb_in_valid;  assign if1.out_ready = tb_out_ready;
   assign if2.in_data = tb_in_data;  assign if2.in_valid = tb_in_valid;  assign if2.out_ready = tb_out_ready;

   pkt_rr_mux #(.WD(WD), .CH(CH), .LOCK_PKT(1), .CW(16)) dut0 (.clk(clk), .rst(rst0), .bus(if0.slave), .pkt_cnt(pc0));
   pkt_rr_mux #(.WD(WD), .CH(CH), .LOCK_PKT(0), .CW(16)) dut1 (.clk(clk), .rst(rst1), .bus(if1.slave), .pkt_cnt(pc1));
   pkt_rr_mux #(.WD(WD), .CH(CH), .LOCK_PKT(1), .CW(4))  dut2 (.clk(clk), .rst(rst2), .bus(if2.slave), .pkt_cnt(pc2));

   always_comb begin
      m_in_ready  = if0.in_ready;
      m_out_valid = if0.out_valid;
      m_out_data  = if0.out_data;
      m_out_chan  = if0.out_chan;
      m_pkt_cnt   = pc0;
      if (sel == 1) begin
         m_in_ready  = if1.in_ready;
         m_out_valid = if1.out_valid;
         m_out_data  = if1.out_data;
         m_out_chan  = if1.out_chan;
         m_pkt_cnt   = pc1;
      end else if (sel == 2) begin
         m_in_ready  = if2.in_ready;
         m_out_valid = if2.out_valid;
         m_out_data  = if2.out_data;
         m_out_chan  = if2.out_chan;
         m_pkt_cnt   = {12'b0, pc2};
      end
   end

   function automatic logic [WD-1:0] mk(input int ch, input int b, input bit eop);
      return {eop, 4'(ch), 4'(b)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int ch, input logic [WD-1:0] d);
      src[ch].push_back(d);
      sb.push_back('{ch: 2'(ch), data: d});
   endtask

   task automatic drive();
      for (int c = 0; c < CH; c++) begin
         tb_in_valid[c]           = (src[c].size() > 0);
         tb_in_data[c*WD +: WD]   = (src[c].size() > 0) ? src[c][0] : '0;
      end
   endtask

   // Observe the DUT at the falling edge: score output transfers, note input acceptances.
   task automatic sample_neg();
      exp_t e;
      @(negedge clk);
      check("ready_onehot", 32'($countones(m_in_ready) <= 1), 32'd1);
      if (m_out_valid && tb_out_ready) begin
         vectors++;
         assert (sb.size() > 0) else begin
            miscompares++;
            $error("FAIL extra_beat observed=%0h expected=none", {m_out_chan, m_out_data});
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("beat", 32'({m_out_chan, m_out_data}), 32'(e));
         end
      end
      acc = m_in_ready & tb_in_valid;
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++)
         if (acc[c]) void'(src[c].pop_front());
      drive();
   endtask

   task automatic drain(input int max_cycles, output int cycles);
      cycles = 0;
      while (sb.size() > 0 && cycles < max_cycles) begin
         sample_neg();
         advance();
         cycles++;
      end
      check("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   task automatic do_reset(input int s);
      sel    = s;
      tb_rst = 1'b1;
      for (int c = 0; c < CH; c++) src[c].delete();
      sb.delete();
      tb_out_ready = 1'b1;
      drive();
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      tb_rst = 1'b0;
   endtask

   initial begin
      int cyc;
      tb_rst       = 1'b1;
      sel          = 0;
      tb_out_ready = 1'b1;
      tb_in_valid  = '0;
      tb_in_data   = '0;
      acc          = '0;

      // Reset with every channel presenting a beat: nothing may be accepted.
      for (int c = 0; c < CH; c++) src[c].push_back(mk(c, 0, 1'b1));
      drive();
      sample_neg();
      check("rst_in_ready", 32'(m_in_ready), 32'd0);
      advance();
      check("rst_out_valid", 32'(m_out_valid), 32'd0);
      check("rst_out_data", 32'(m_out_data), 32'd0);
      check("rst_out_chan", 32'(m_out_chan), 32'd0);
      check("rst_pkt_cnt", 32'(m_pkt_cnt), 32'd0);

      // Packet lock: ch0 and ch2 send 3-beat packets together; no interleave.
      do_reset(0);
      for (int b = 0; b < 3; b++) src[0].push_back(mk(0, b, b == 2));
      for (int b = 0; b < 3; b++) src[2].push_back(mk(2, b, b == 2));
      for (int b = 0; b < 3; b++) sb.push_back('{ch: 2'd0, data: mk(0, b, b == 2)});
      for (int b = 0; b < 3; b++) sb.push_back('{ch: 2'd2, data: mk(2, b, b == 2)});
      drive();
      drain(40, cyc);
      check("lock_pkt_cnt", 32'(m_pkt_cnt), 32'd2);

      // Beat-granular: same stimulus alternates ch0, ch2.
      do_reset(1);
      for (int b = 0; b < 3; b++) src[0].push_back(mk(0, b, b == 2));
      for (int b = 0; b < 3; b++) src[2].push_back(mk(2, b, b == 2));
      for (int b = 0; b < 3; b++) begin
         sb.push_back('{ch: 2'd0, data: mk(0, b, b == 2)});
         sb.push_back('{ch: 2'd2, data: mk(2, b, b == 2)});
      end
      drive();
      drain(40, cyc);
      check("beat_pkt_cnt", 32'(m_pkt_cnt), 32'd2);

      // Four channels of single-beat packets: 0,1,2,3,0,1,2,3 back to back.
      do_reset(0);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < CH; c++) push(c, mk(c, r, 1'b1));
      drive();
      drain(40, cyc);
      check("no_bubble_cycles", 32'(cyc), 32'd9);
      check("rr_pkt_cnt", 32'(m_pkt_cnt), 32'd8);

      // Backpressure: registered beat held stable for 5 cycles, nothing lost.
      do_reset(0);
      push(1, mk(1, 10, 1'b1));
      push(3, mk(3, 11, 1'b1));
      drive();
      sample_neg();
      advance();
      tb_out_ready = 1'b0;
      repeat (5) begin
         sample_neg();
         check("bp_out_valid", 32'(m_out_valid), 32'd1);
         check("bp_out_data", 32'(m_out_data), 32'(mk(1, 10, 1'b1)));
         check("bp_out_chan", 32'(m_out_chan), 32'd1);
         check("bp_in_ready", 32'(m_in_ready), 32'd0);
         advance();
      end
      tb_out_ready = 1'b1;
      drain(20, cyc);
      check("bp_pkt_cnt", 32'(m_pkt_cnt), 32'd2);

      // Reset after beat 2 of a 4-beat ch1 packet: lock and held beat discarded.
      do_reset(0);
      for (int b = 0; b < 4; b++) src[1].push_back(mk(1, b, b == 3));
      sb.push_back('{ch: 2'd1, data: mk(1, 0, 1'b0)});
      drive();
      repeat (2) begin
         sample_neg();
         advance();
      end
      tb_rst       = 1'b1;
      tb_out_ready = 1'b0;
      sample_neg();
      check("midrst_in_ready", 32'(m_in_ready), 32'd0);
      advance();
      tb_rst       = 1'b0;
      tb_out_ready = 1'b1;
      src[1].delete();
      check("midrst_out_valid", 32'(m_out_valid), 32'd0);
      push(3, mk(3, 5, 1'b1));
      drive();
      drain(20, cyc);
      push(1, mk(1, 6, 1'b1));
      drive();
      drain(20, cyc);
      check("midrst_pkt_cnt", 32'(m_pkt_cnt), 32'd2);

      // Narrow counter: 17 packets wrap a 4-bit count to 1.
      do_reset(2);
      for (int i = 0; i < 17; i++) push(0, {1'b1, 8'(i)});
      drive();
      drain(80, cyc);
      check("wrap_pkt_cnt", 32'(m_pkt_cnt), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
